// File: rtl/reset_sequencer.sv
// Releases N_DOM reset domains one at a time in index order, waiting for each
// domain's acknowledge before moving on; a missing acknowledge parks it in FAULT.
module reset_sequencer #(
  parameter int N_DOM   = 4,
  parameter int DELAY   = 8,
  parameter int ACK_TMO = 255
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             soft_rst_req,
  input  logic [N_DOM-1:0] dom_ack,
  output logic [N_DOM-1:0] dom_rstn,
  output logic             all_up,
  output logic             busy,
  output logic             fault,
  output logic [2:0]       fault_dom
);

  localparam logic [7:0] HOLD_LAST = 8'(DELAY - 1);
  localparam logic [7:0] TMO_LAST  = 8'(ACK_TMO - 1);
  localparam logic [2:0] IDX_LAST  = 3'(N_DOM - 1);

  typedef enum logic [1:0] {HOLD, WAIT_ACK, DONE, FAULT} state_e;

  state_e             state_q, state_d;
  logic [7:0]         cnt_q, cnt_d;
  logic [2:0]         idx_q, idx_d;
  logic [N_DOM-1:0]   dom_rstn_q, dom_rstn_d;
  logic               all_up_q, all_up_d;
  logic               busy_q, busy_d;
  logic               fault_q, fault_d;
  logic [2:0]         fault_dom_q, fault_dom_d;
  logic [N_DOM-1:0]   idx_mask;
  logic               ack_sel;

  // One-hot view of the current domain; acks from every other domain are masked off.
  always_comb begin
    idx_mask = '0;
    for (int i = 0; i < N_DOM; i++) begin
      idx_mask[i] = (idx_q == 3'(i));
    end
    ack_sel = |(dom_ack & idx_mask);
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    idx_d       = idx_q;
    dom_rstn_d  = dom_rstn_q;
    all_up_d    = all_up_q;
    busy_d      = busy_q;
    fault_d     = fault_q;
    fault_dom_d = fault_dom_q;

    if (soft_rst_req) begin
      state_d     = HOLD;
      cnt_d       = '0;
      idx_d       = '0;
      dom_rstn_d  = '0;
      all_up_d    = 1'b0;
      busy_d      = 1'b1;
      fault_d     = 1'b0;
      fault_dom_d = '0;
    end else begin
      unique case (state_q)
        HOLD: begin
          if (cnt_q == HOLD_LAST) begin
            dom_rstn_d = dom_rstn_q | idx_mask;
            cnt_d      = '0;
            state_d    = WAIT_ACK;
          end else begin
            cnt_d = cnt_q + 8'd1;
          end
        end
        WAIT_ACK: begin
          // Acknowledge is tested before the timeout so a same-edge ack wins.
          if (ack_sel) begin
            cnt_d = '0;
            if (idx_q == IDX_LAST) begin
              state_d  = DONE;
              all_up_d = 1'b1;
              busy_d   = 1'b0;
            end else begin
              idx_d   = idx_q + 3'd1;
              state_d = HOLD;
            end
          end else if (cnt_q == TMO_LAST) begin
            cnt_d       = '0;
            state_d     = FAULT;
            dom_rstn_d  = dom_rstn_q & ~idx_mask;
            fault_d     = 1'b1;
            fault_dom_d = idx_q;
            busy_d      = 1'b0;
          end else begin
            cnt_d = cnt_q + 8'd1;
          end
        end
        DONE:    ;
        FAULT:   ;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q     <= HOLD;
      cnt_q       <= '0;
      idx_q       <= '0;
      dom_rstn_q  <= '0;
      all_up_q    <= 1'b0;
      busy_q      <= 1'b1;
      fault_q     <= 1'b0;
      fault_dom_q <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      idx_q       <= idx_d;
      dom_rstn_q  <= dom_rstn_d;
      all_up_q    <= all_up_d;
      busy_q      <= busy_d;
      fault_q     <= fault_d;
      fault_dom_q <= fault_dom_d;
    end
  end

  assign dom_rstn  = dom_rstn_q;
  assign all_up    = all_up_q;
  assign busy      = busy_q;
  assign fault     = fault_q;
  assign fault_dom = fault_dom_q;

endmodule

// File: tb/tb_reset_sequencer.sv
// Directed scoreboard bench for reset_sequencer (N_DOM=3, DELAY=4, ACK_TMO=10);
// expectations are queued per edge number and popped when that edge is sampled.
module tb_reset_sequencer;

  logic       clk = 1'b0;
  logic       rstn = 1'b0;
  logic       soft_rst_req = 1'b0;
  logic [2:0] dom_ack;
  logic [2:0] dom_rstn;
  logic       all_up, busy, fault;
  logic [2:0] fault_dom;

  logic [2:0] ack_en = '0;
  logic [2:0] manual = '0;
  logic [2:0] noise = '0;
  logic [2:0] rstn_d1 = '0;

  typedef struct {
    int         at;
    logic [8:0] exp;
    string      tag;
  } exp_t;

  exp_t sb[$];
  int   edge_no = 0;
  int   checks = 0;
  int   errors = 0;

  reset_sequencer #(.N_DOM(3), .DELAY(4), .ACK_TMO(10)) dut (
    .clk          (clk),
    .rstn         (rstn),
    .soft_rst_req (soft_rst_req),
    .dom_ack      (dom_ack),
    .dom_rstn     (dom_rstn),
    .all_up       (all_up),
    .busy         (busy),
    .fault        (fault),
    .fault_dom    (fault_dom)
  );

  always #5 clk = ~clk;

  // Enabled domains acknowledge on the second edge after their release.
  always @(posedge clk) rstn_d1 <= dom_rstn;
  assign dom_ack = ((ack_en & rstn_d1 & dom_rstn) | manual) ^ noise;

  function automatic logic [8:0] pk(input logic [2:0] r, input logic up, input logic b,
                                    input logic f, input logic [2:0] fd);
    return {r, up, b, f, fd};
  endfunction

  task automatic expectAt(input int at, input logic [8:0] e, input string tag);
    exp_t x;
    x.at  = at;
    x.exp = e;
    x.tag = tag;
    sb.push_back(x);
  endtask

  task automatic checkOutput();
    exp_t       e;
    logic [8:0] obs;
    e   = sb.pop_front();
    obs = {dom_rstn, all_up, busy, fault, fault_dom};
    checks++;
    assert (obs === e.exp) else begin
      errors++;
      $error("[TB] FAIL %s @edge %0d: observed %b, expected %b (dom_rstn,all_up,busy,fault,fault_dom)",
             e.tag, edge_no, obs, e.exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    edge_no++;
    while (sb.size() > 0 && sb[0].at <= edge_no) checkOutput();
  endtask

  task automatic applyStimulus(input logic s, input logic [2:0] en, input logic [2:0] man);
    soft_rst_req = s;
    ack_en       = en;
    manual       = man;
  endtask

  task automatic softPulse(input string tag);
    soft_rst_req = 1'b1;
    edge_no = -1;
    expectAt(0, pk(3'b000, 0, 1, 0, 3'd0), tag);
    tick();
    soft_rst_req = 1'b0;
  endtask

  task automatic expectNominal(input string p);
    expectAt(3,  pk(3'b000, 0, 1, 0, 3'd0), {p, "_hold0_e3"});
    expectAt(4,  pk(3'b001, 0, 1, 0, 3'd0), {p, "_rel0_e4"});
    expectAt(9,  pk(3'b001, 0, 1, 0, 3'd0), {p, "_hold1_e9"});
    expectAt(10, pk(3'b011, 0, 1, 0, 3'd0), {p, "_rel1_e10"});
    expectAt(16, pk(3'b111, 0, 1, 0, 3'd0), {p, "_rel2_e16"});
    expectAt(17, pk(3'b111, 0, 1, 0, 3'd0), {p, "_wait2_e17"});
    expectAt(18, pk(3'b111, 1, 0, 0, 3'd0), {p, "_done_e18"});
  endtask

  initial begin
    // Reset held for two edges.
    applyStimulus(1'b0, 3'b000, 3'b000);
    tick();
    tick();
    expectAt(edge_no, pk(3'b000, 0, 1, 0, 3'd0), "reset_state");
    checkOutput();

    // Nominal run with noise on dom_ack[2] while idx=0 and on dom_ack[0] after DONE.
    applyStimulus(1'b0, 3'b111, 3'b000);
    rstn = 1'b1;
    edge_no = 0;
    expectNominal("nom");
    expectAt(20, pk(3'b111, 1, 0, 0, 3'd0), "nom_noise_done_e20");
    expectAt(22, pk(3'b111, 1, 0, 0, 3'd0), "nom_noise_done_e22");
    expectAt(24, pk(3'b111, 1, 0, 0, 3'd0), "nom_noise_done_e24");
    for (int k = 1; k <= 24; k++) begin
      tick();
      noise[2] = (k <= 4) ? ~noise[2] : 1'b0;
      noise[0] = (k >= 18 && k <= 22) ? ~noise[0] : 1'b0;
    end

    // Domain 1 never acknowledges: timeout on the 10th WAIT_ACK edge.
    applyStimulus(1'b0, 3'b101, 3'b000);
    softPulse("tmo_soft_e0");
    expectAt(4,  pk(3'b001, 0, 1, 0, 3'd0), "tmo_rel0_e4");
    expectAt(10, pk(3'b011, 0, 1, 0, 3'd0), "tmo_rel1_e10");
    expectAt(19, pk(3'b011, 0, 1, 0, 3'd0), "tmo_wait1_e19");
    expectAt(20, pk(3'b001, 0, 0, 1, 3'd1), "tmo_fault_e20");
    expectAt(40, pk(3'b001, 0, 0, 1, 3'd1), "tmo_sticky_e40");
    while (edge_no < 40) tick();

    // Recovery from FAULT via a one-cycle soft request.
    applyStimulus(1'b0, 3'b111, 3'b000);
    softPulse("rec_soft_e0");
    expectNominal("rec");
    while (edge_no < 19) tick();

    // Same-edge race on domain 0, then async reset while domain 2 waits.
    applyStimulus(1'b0, 3'b010, 3'b000);
    softPulse("race_soft_e0");
    expectAt(4,  pk(3'b001, 0, 1, 0, 3'd0), "race_rel0_e4");
    expectAt(13, pk(3'b001, 0, 1, 0, 3'd0), "race_wait_e13");
    expectAt(14, pk(3'b001, 0, 1, 0, 3'd0), "race_ackwins_e14");
    expectAt(17, pk(3'b001, 0, 1, 0, 3'd0), "race_hold1_e17");
    expectAt(18, pk(3'b011, 0, 1, 0, 3'd0), "race_rel1_e18");
    expectAt(20, pk(3'b011, 0, 1, 0, 3'd0), "race_ack1_e20");
    expectAt(24, pk(3'b111, 0, 1, 0, 3'd0), "race_rel2_e24");
    expectAt(25, pk(3'b111, 0, 1, 0, 3'd0), "race_wait2_e25");
    while (edge_no < 25) begin
      tick();
      if (edge_no == 13) manual[0] = 1'b1;
    end
    #2;
    applyStimulus(1'b0, 3'b111, 3'b000);
    rstn = 1'b0;
    #1;
    expectAt(edge_no, pk(3'b000, 0, 1, 0, 3'd0), "async_rehold");
    checkOutput();
    tick();
    rstn = 1'b1;
    edge_no = 0;
    expectNominal("restart");
    while (edge_no < 19) tick();

    if (sb.size() != 0) begin
      checks++;
      errors++;
      $display("[TB] FAIL scoreboard_drain: observed %0d pending, expected 0", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
